display_serializer: RTL and testbench



---
 rtl/display_serializer.sv | 185 ++++++++++++++++++
 tb/tb_display_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_serializer.sv
// rtl/display_serializer.sv - six-digit 7-segment frame serializer for 74HC595-style chains
module display_serializer #(
    parameter int SYS_CLK_HZ   = 5_000_000,
    parameter int SHIFT_CLK_HZ = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_write,
    input  logic [23:0] i_bcd,
    input  logic [5:0]  i_dp,
    output logic        o_busy,
    output logic        o_serial_data,
    output logic        o_serial_clk,
    output logic        o_serial_latch
);

    localparam int HP_RAW      = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
    localparam int HALF_PERIOD = (HP_RAW < 1) ? 1 : HP_RAW;
    localparam int PW          = $clog2(4 * HALF_PERIOD);

    localparam logic [PW-1:0] HP_LAST    = PW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] LATCH_ON   = PW'(2 * HALF_PERIOD);
    localparam logic [PW-1:0] LATCH_LAST = PW'(4 * HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    state_t         state, state_next;
    logic [PW-1:0]  phase_cnt, phase_cnt_next;
    logic [5:0]     bit_cnt, bit_cnt_next;
    logic [47:0]    shift_reg, shift_reg_next;
    logic           pend_valid, pend_valid_next;
    logic [23:0]    pend_bcd, pend_bcd_next;
    logic [5:0]     pend_dp, pend_dp_next;
    logic           busy_next, data_next, sclk_next, latch_next;
    logic [23:0]    sel_bcd;
    logic [5:0]     sel_dp;
    logic [47:0]    start_frame;

    function automatic logic [7:0] seg_byte(input logic [3:0] digit, input logic dp);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return {dp, seg};
    endfunction

    // Digit 5 lands in the top byte so it leaves the shift register first.
    function automatic logic [47:0] encode_frame(input logic [23:0] bcd, input logic [5:0] dp);
        logic [47:0] frame;
        frame = '0;
        for (int n = 0; n < 6; n++) begin
            frame[n*8 +: 8] = seg_byte(bcd[n*4 +: 4], dp[n]);
        end
        return frame;
    endfunction

    // A fresh write takes priority over the buffered frame when both are available.
    assign sel_bcd     = i_write ? i_bcd : pend_bcd;
    assign sel_dp      = i_write ? i_dp  : pend_dp;
    assign start_frame = encode_frame(sel_bcd, sel_dp);

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_next      = state;
        phase_cnt_next  = phase_cnt;
        bit_cnt_next    = bit_cnt;
        shift_reg_next  = shift_reg;
        pend_valid_next = pend_valid;
        pend_bcd_next   = pend_bcd;
        pend_dp_next    = pend_dp;
        busy_next       = o_busy;
        data_next       = o_serial_data;
        sclk_next       = o_serial_clk;
        latch_next      = o_serial_latch;

        if (i_write) begin
            pend_valid_next = 1'b1;
            pend_bcd_next   = i_bcd;
            pend_dp_next    = i_dp;
        end

        case (state)
            IDLE: begin
                if (i_en && (i_write || pend_valid)) begin
                    pend_valid_next = 1'b0;
                    shift_reg_next  = start_frame;
                    state_next      = SHIFT_LO;
                    phase_cnt_next  = '0;
                    bit_cnt_next    = '0;
                    busy_next       = 1'b1;
                    sclk_next       = 1'b0;
                    latch_next      = 1'b0;
                    data_next       = start_frame[47];
                end
            end
            SHIFT_LO: begin
                if (phase_cnt == HP_LAST) begin
                    phase_cnt_next = '0;
                    sclk_next      = 1'b1;
                    state_next     = SHIFT_HI;
                end else begin
                    phase_cnt_next = phase_cnt + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (phase_cnt == HP_LAST) begin
                    phase_cnt_next = '0;
                    sclk_next      = 1'b0;
                    if (bit_cnt == 6'd47) begin
                        data_next  = 1'b0;
                        state_next = LATCH;
                    end else begin
                        bit_cnt_next   = bit_cnt + 1'b1;
                        shift_reg_next = {shift_reg[46:0], 1'b0};
                        data_next      = shift_reg[46];
                        state_next     = SHIFT_LO;
                    end
                end else begin
                    phase_cnt_next = phase_cnt + 1'b1;
                end
            end
            LATCH: begin
                // Quiet guard interval after the last clock fall, then the latch pulse.
                if (phase_cnt == LATCH_LAST) begin
                    phase_cnt_next = '0;
                    latch_next     = 1'b0;
                    busy_next      = 1'b0;
                    state_next     = IDLE;
                end else begin
                    phase_cnt_next = phase_cnt + 1'b1;
                    if (phase_cnt_next == LATCH_ON) begin
                        latch_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and output registers; reset clears everything immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= IDLE;
            phase_cnt      <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            pend_valid     <= 1'b0;
            pend_bcd       <= '0;
            pend_dp        <= '0;
            o_busy         <= 1'b0;
            o_serial_data  <= 1'b0;
            o_serial_clk   <= 1'b0;
            o_serial_latch <= 1'b0;
        end else begin
            state          <= state_next;
            phase_cnt      <= phase_cnt_next;
            bit_cnt        <= bit_cnt_next;
            shift_reg      <= shift_reg_next;
            pend_valid     <= pend_valid_next;
            pend_bcd       <= pend_bcd_next;
            pend_dp        <= pend_dp_next;
            o_busy         <= busy_next;
            o_serial_data  <= data_next;
            o_serial_clk   <= sclk_next;
            o_serial_latch <= latch_next;
        end
    end

endmodule

// File: tb/tb_display_serializer.sv
// tb/tb_display_serializer.sv - directed self-checking bench for display_serializer
module tb_display_serializer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_en = 1'b1;
    logic        i_write = 1'b0;
    logic        i_write2 = 1'b0;
    logic [23:0] i_bcd = '0;
    logic [5:0]  i_dp = '0;
    logic        o_busy, o_serial_data, o_serial_clk, o_serial_latch;
    logic        busy2, sdata2, sclk2, latch2;

    int checks = 0;
    int errors = 0;

    display_serializer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_write(i_write),
        .i_bcd(i_bcd), .i_dp(i_dp), .o_busy(o_busy), .o_serial_data(o_serial_data),
        .o_serial_clk(o_serial_clk), .o_serial_latch(o_serial_latch)
    );

    display_serializer #(.SYS_CLK_HZ(2_000_000), .SHIFT_CLK_HZ(1_000_000)) dut_fast (
        .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_write(i_write2),
        .i_bcd(i_bcd), .i_dp(i_dp), .o_busy(busy2), .o_serial_data(sdata2),
        .o_serial_clk(sclk2), .o_serial_latch(latch2)
    );

    always #5 i_clk = ~i_clk;

    // Receiver model: samples on serial clock rising edges, tallies activity.
    logic bits[$];
    int   cyc = 0, busy_cnt = 0, latch_cnt = 0, last_fall = 0, latch_rise = 0;
    int   rise2 = 0, busy2_cnt = 0, hi_viol2 = 0;
    logic prev_sclk = 1'b0, prev_latch = 1'b0, prev_sclk2 = 1'b0;

    always @(negedge i_clk) begin
        cyc <= cyc + 1;
        if (o_serial_clk && !prev_sclk) bits.push_back(o_serial_data);
        if (!o_serial_clk && prev_sclk) last_fall <= cyc;
        if (o_serial_latch && !prev_latch) latch_rise <= cyc;
        if (o_serial_latch) latch_cnt <= latch_cnt + 1;
        if (o_busy) busy_cnt <= busy_cnt + 1;
        if (sclk2 && !prev_sclk2) rise2 <= rise2 + 1;
        if (sclk2 && prev_sclk2) hi_viol2 <= hi_viol2 + 1;
        if (busy2) busy2_cnt <= busy2_cnt + 1;
        prev_sclk  <= o_serial_clk;
        prev_latch <= o_serial_latch;
        prev_sclk2 <= sclk2;
    end

    function automatic logic [7:0] get_byte(input int start, input int k);
        logic [7:0] b;
        b = '0;
        for (int j = 0; j < 8; j++) b = {b[6:0], bits[start + 8*k + j]};
        return b;
    endfunction

    task automatic pulse_write(input logic [23:0] bcd, input logic [5:0] dp);
        @(posedge i_clk); #1;
        i_bcd = bcd; i_dp = dp; i_write = 1'b1;
        @(posedge i_clk); #1;
        i_write = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input int budget, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge i_clk);
            waited = n + 1;
            if (o_busy === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        checks++; if (o_serial_data !== 1'b0) begin errors++; $display("FAIL reset_data got %b want 0", o_serial_data); end
        checks++; if (o_serial_clk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", o_serial_clk); end
        checks++; if (o_serial_latch !== 1'b0) begin errors++; $display("FAIL reset_latch got %b want 0", o_serial_latch); end
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_single();
        logic [7:0] exp_b[6] = '{8'h06, 8'h5B, 8'h4F, 8'hE6, 8'h6D, 8'h7D};
        int b0, bc0, lc0, w;
        bit ok;
        b0 = bits.size(); bc0 = busy_cnt; lc0 = latch_cnt;
        pulse_write(24'h123456, 6'b000100);
        wait_busy(1'b1, 5, ok, w);
        checks++; if (!ok) begin errors++; $display("FAIL single_start got timeout want busy"); end
        wait_busy(1'b0, 400, ok, w);
        checks++; if (!ok) begin errors++; $display("FAIL single_end got timeout want idle"); end
        checks++; if (bits.size() - b0 != 48) begin errors++; $display("FAIL single_edges got %0d want 48", bits.size() - b0); end
        if (bits.size() - b0 >= 48) begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (get_byte(b0, k) !== exp_b[k]) begin
                    errors++; $display("FAIL single_byte%0d got %h want %h", k, get_byte(b0, k), exp_b[k]);
                end
            end
        end
        checks++; if (busy_cnt - bc0 != 200) begin errors++; $display("FAIL single_busy_len got %0d want 200", busy_cnt - bc0); end
        checks++; if (latch_cnt - lc0 != 4) begin errors++; $display("FAIL single_latch_len got %0d want 4", latch_cnt - lc0); end
        checks++; if (latch_rise - last_fall != 4) begin errors++; $display("FAIL single_latch_gap got %0d want 4", latch_rise - last_fall); end
    endtask

    task automatic test_blank_dp();
        logic [7:0] exp_b[6] = '{8'h80, 8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
        int b0, w;
        bit ok;
        b0 = bits.size();
        pulse_write(24'hFA0000, 6'b100000);
        wait_busy(1'b1, 5, ok, w);
        wait_busy(1'b0, 400, ok, w);
        checks++; if (!ok || bits.size() - b0 != 48) begin errors++; $display("FAIL blank_edges got %0d want 48", bits.size() - b0); end
        if (bits.size() - b0 >= 48) begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (get_byte(b0, k) !== exp_b[k]) begin
                    errors++; $display("FAIL blank_byte%0d got %h want %h", k, get_byte(b0, k), exp_b[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int b0, w;
        bit ok;
        b0 = bits.size();
        pulse_write(24'h000000, 6'b000000);
        repeat (48) @(posedge i_clk);
        pulse_write(24'h111111, 6'b000000);
        repeat (8) @(posedge i_clk);
        pulse_write(24'h222222, 6'b000000);
        wait_busy(1'b0, 400, ok, w);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_end got timeout want idle"); end
        wait_busy(1'b1, 10, ok, w);
        checks++; if (!ok || w != 1) begin errors++; $display("FAIL b2b_gap got %0d want 1", w); end
        wait_busy(1'b0, 400, ok, w);
        repeat (300) @(negedge i_clk);
        checks++; if (bits.size() - b0 != 96) begin errors++; $display("FAIL b2b_edges got %0d want 96", bits.size() - b0); end
        if (bits.size() - b0 >= 96) begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (get_byte(b0, k) !== (k < 6 ? 8'h3F : 8'h5B)) begin
                    errors++; $display("FAIL b2b_byte%0d got %h want %h", k, get_byte(b0, k), (k < 6 ? 8'h3F : 8'h5B));
                end
            end
        end
    endtask

    task automatic test_enable();
        int b0, bc0, w;
        bit ok;
        i_en = 1'b0;
        b0 = bits.size(); bc0 = busy_cnt;
        pulse_write(24'h999999, 6'b000000);
        repeat (500) @(negedge i_clk);
        checks++; if (busy_cnt - bc0 != 0) begin errors++; $display("FAIL en_gated_busy got %0d want 0", busy_cnt - bc0); end
        checks++; if (bits.size() - b0 != 0) begin errors++; $display("FAIL en_gated_edges got %0d want 0", bits.size() - b0); end
        @(posedge i_clk); #1;
        i_en = 1'b1;
        wait_busy(1'b1, 2, ok, w);
        checks++; if (!ok) begin errors++; $display("FAIL en_start got timeout want busy within 2"); end
        wait_busy(1'b0, 400, ok, w);
        checks++; if (bits.size() - b0 != 48) begin errors++; $display("FAIL en_edges got %0d want 48", bits.size() - b0); end
        if (bits.size() - b0 >= 48) begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (get_byte(b0, k) !== 8'h6F) begin
                    errors++; $display("FAIL en_byte%0d got %h want 6f", k, get_byte(b0, k));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bc0, w;
        bit ok;
        pulse_write(24'h000000, 6'b000000);
        pulse_write(24'h111111, 6'b000000);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_clk);
            if (o_serial_clk === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_sclk got timeout want sclk high"); end
        i_reset = 1'b1;
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", o_busy); end
        checks++; if (o_serial_clk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk_low got %b want 0", o_serial_clk); end
        checks++; if (o_serial_data !== 1'b0) begin errors++; $display("FAIL rstmid_data got %b want 0", o_serial_data); end
        checks++; if (o_serial_latch !== 1'b0) begin errors++; $display("FAIL rstmid_latch got %b want 0", o_serial_latch); end
        @(negedge i_clk);
        i_reset = 1'b0;
        bc0 = busy_cnt;
        repeat (300) @(negedge i_clk);
        checks++; if (busy_cnt - bc0 != 0) begin errors++; $display("FAIL rstmid_no_frame got %0d want 0", busy_cnt - bc0); end
        w = 0;
    endtask

    task automatic test_divider();
        int r0, bc0, v0;
        bit ok;
        r0 = rise2; bc0 = busy2_cnt; v0 = hi_viol2;
        @(posedge i_clk); #1;
        i_bcd = 24'h000000; i_dp = 6'b000000; i_write2 = 1'b1;
        @(posedge i_clk); #1;
        i_write2 = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge i_clk);
            if (busy2_cnt > bc0 && busy2 === 1'b0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL div_end got timeout want idle"); end
        checks++; if (busy2_cnt - bc0 != 100) begin errors++; $display("FAIL div_busy_len got %0d want 100", busy2_cnt - bc0); end
        checks++; if (rise2 - r0 != 48) begin errors++; $display("FAIL div_edges got %0d want 48", rise2 - r0); end
        checks++; if (hi_viol2 - v0 != 0) begin errors++; $display("FAIL div_toggle got %0d want 0", hi_viol2 - v0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_blank_dp();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_divider();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
